// File: rtl/crc_frame_arbiter.sv
// Two-requester round-robin arbiter feeding a shared bytewise CRC engine.
// Each grant covers one whole frame; the finished CRC is offered on a valid/ready handshake.
module crc_frame_arbiter #(
    parameter        POLY       = 8'h07,
    parameter        INIT       = 8'h00,
    parameter int    REFLECT    = 0,
    parameter        XOR_OUT    = 8'h00,
    parameter int    DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   req0_data_i,
    input  logic                    req0_valid_i,
    input  logic                    req0_last_i,
    output logic                    req0_ready_o,
    input  logic [DATA_WIDTH-1:0]   req1_data_i,
    input  logic                    req1_valid_i,
    input  logic                    req1_last_i,
    output logic                    req1_ready_o,
    output logic [$bits(POLY)-1:0]  crc_o,
    output logic                    crc_src_o,
    output logic [15:0]             len_o,
    output logic                    crc_valid_o,
    input  logic                    crc_ready_i
);
    localparam int CW = $bits(POLY);
    localparam logic [CW-1:0] POLY_L = POLY;
    localparam logic [CW-1:0] INIT_L = INIT;
    localparam logic [CW-1:0] XOR_L  = XOR_OUT;

    typedef enum logic [1:0] {IDLE, BUSY, RESULT} state_t;

    state_t                  state_q, state_d;
    logic                    own_q, own_d;
    logic                    rr_q, rr_d;
    logic [CW-1:0]           crc_q, crc_d;
    logic [15:0]             len_q, len_d;
    logic                    beat_v, beat_last;
    logic [DATA_WIDTH-1:0]   beat_data;
    logic [CW-1:0]           crc_fin;

    // Bytes are optionally mirrored first, then the beat is shifted in MSB-first.
    function automatic logic [CW-1:0] crc_beat(input logic [CW-1:0] c,
                                               input logic [DATA_WIDTH-1:0] d);
        logic [CW-1:0]         r;
        logic [DATA_WIDTH-1:0] x;
        r = c;
        x = d;
        if (REFLECT != 0) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++)
                for (int k = 0; k < 8; k++)
                    x[b*8+k] = d[b*8+7-k];
        end
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (r[CW-1] ^ x[i]) r = (r << 1) ^ POLY_L;
            else                r = r << 1;
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] c);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < CW; i++) r[i] = c[CW-1-i];
        return r;
    endfunction

    assign beat_v    = own_q ? req1_valid_i : req0_valid_i;
    assign beat_last = own_q ? req1_last_i  : req0_last_i;
    assign beat_data = own_q ? req1_data_i  : req0_data_i;
    assign crc_fin   = ((REFLECT != 0) ? bitrev(crc_q) : crc_q) ^ XOR_L;

    always_comb begin
        state_d      = state_q;
        own_d        = own_q;
        rr_d         = rr_q;
        crc_d        = crc_q;
        len_d        = len_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        crc_valid_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid_i || req1_valid_i) begin
                    // rr_q holds the last owner; on contention the other side wins.
                    own_d   = (req0_valid_i && req1_valid_i) ? ~rr_q : req1_valid_i;
                    crc_d   = INIT_L;
                    len_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                req0_ready_o = ~own_q;
                req1_ready_o = own_q;
                if (beat_v) begin
                    crc_d = crc_beat(crc_q, beat_data);
                    if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
                    if (beat_last) state_d = RESULT;
                end
            end
            RESULT: begin
                crc_valid_o = 1'b1;
                if (crc_ready_i) begin
                    state_d = IDLE;
                    rr_d    = own_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign crc_o     = (state_q == RESULT) ? crc_fin : '0;
    assign crc_src_o = (state_q == RESULT) ? own_q   : 1'b0;
    assign len_o     = (state_q == RESULT) ? len_q   : 16'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            own_q   <= 1'b0;
            rr_q    <= 1'b1;
            crc_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            rr_q    <= rr_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
        end
    end
endmodule

// File: tb/tb_crc_frame_arbiter.sv
// Scoreboard bench: CRC-8 instance for arbitration/handshake cases, CRC-32 instance for the reflected check.
module tb_crc_frame_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  a_d0, a_d1, b_d0, b_d1;
    logic        a_v0, a_l0, a_r0, a_v1, a_l1, a_r1;
    logic        b_v0, b_l0, b_r0, b_v1, b_l1, b_r1;
    logic [7:0]  a_crc;
    logic [31:0] b_crc;
    logic        a_src, b_src, a_cv, b_cv, a_cr, b_cr;
    logic [15:0] a_len, b_len;

    crc_frame_arbiter u_a (
        .clk(clk), .reset(reset),
        .req0_data_i(a_d0), .req0_valid_i(a_v0), .req0_last_i(a_l0), .req0_ready_o(a_r0),
        .req1_data_i(a_d1), .req1_valid_i(a_v1), .req1_last_i(a_l1), .req1_ready_o(a_r1),
        .crc_o(a_crc), .crc_src_o(a_src), .len_o(a_len),
        .crc_valid_o(a_cv), .crc_ready_i(a_cr)
    );

    crc_frame_arbiter #(
        .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .REFLECT(1),
        .XOR_OUT(32'hFFFFFFFF), .DATA_WIDTH(8)
    ) u_b (
        .clk(clk), .reset(reset),
        .req0_data_i(b_d0), .req0_valid_i(b_v0), .req0_last_i(b_l0), .req0_ready_o(b_r0),
        .req1_data_i(b_d1), .req1_valid_i(b_v1), .req1_last_i(b_l1), .req1_ready_o(b_r1),
        .crc_o(b_crc), .crc_src_o(b_src), .len_o(b_len),
        .crc_valid_o(b_cv), .crc_ready_i(b_cr)
    );

    typedef struct {
        logic [31:0] crc;
        logic        src;
        logic [15:0] len;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [7:0] s123[16];
    logic [7:0] one_b[16];
    logic [7:0] two_b[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input int d, input int r, input logic v, input logic [7:0] data,
                         input logic last);
        case ({d[0], r[0]})
            2'b00: begin a_v0 = v; a_d0 = data; a_l0 = last; end
            2'b01: begin a_v1 = v; a_d1 = data; a_l1 = last; end
            2'b10: begin b_v0 = v; b_d0 = data; b_l0 = last; end
            default: begin b_v1 = v; b_d1 = data; b_l1 = last; end
        endcase
    endtask

    function automatic logic rdy(input int d, input int r);
        case ({d[0], r[0]})
            2'b00:   return a_r0;
            2'b01:   return a_r1;
            2'b10:   return b_r0;
            default: return b_r1;
        endcase
    endfunction

    function automatic logic cv(input int d);
        return (d == 0) ? a_cv : b_cv;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send n beats; with gap_len>0, valid drops for gap_len cycles before beat gap_at.
    task automatic send(input int d, input int r, input logic [7:0] bytes[16], input int n,
                        input logic send_last, input int gap_at, input int gap_len);
        int t;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                repeat (gap_len) begin
                    drive(d, r, 1'b0, 8'h00, 1'b0);
                    @(negedge clk);
                    chk("gap_other_ready", {31'd0, rdy(d, 1 - r)}, 32'd0);
                    @(posedge clk);
                    #1;
                end
            end
            drive(d, r, 1'b1, bytes[i], send_last && (i == n - 1));
            t = 0;
            @(negedge clk);
            while (!rdy(d, r) && t < 200) begin
                t++;
                @(negedge clk);
            end
            if (t >= 200) begin
                n_chk++;
                $display("FAIL ready_timeout dut=%0d req=%0d beat=%0d: ready never rose", d, r, i);
                drive(d, r, 1'b0, 8'h00, 1'b0);
                return;
            end
            @(posedge clk);
            #1;
        end
        drive(d, r, 1'b0, 8'h00, 1'b0);
        if (send_last) begin
            @(negedge clk);
            chk("latency_crc_valid", {31'd0, cv(d)}, 32'd1);
        end
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk({name, "_a"}, {a_crc, a_src, a_len, a_cv, a_r0, a_r1}, 32'd0);
        chk({name, "_b"}, {b_crc[4:0], b_src, b_len, b_cv, b_r0, b_r1}, 32'd0);
        chk({name, "_b_crc"}, b_crc, 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset && a_cv && a_cr) begin
            if (qa.size() == 0) begin
                n_chk++;
                $display("FAIL a_unexpected_result: got crc %0h src %0d, expected no result", a_crc, a_src);
            end else begin
                ea = qa.pop_front();
                chk("a_crc", {24'd0, a_crc}, ea.crc);
                chk("a_src", {31'd0, a_src}, {31'd0, ea.src});
                chk("a_len", {16'd0, a_len}, {16'd0, ea.len});
            end
        end
        if (!reset && b_cv && b_cr) begin
            if (qb.size() == 0) begin
                n_chk++;
                $display("FAIL b_unexpected_result: got crc %0h, expected no result", b_crc);
            end else begin
                eb = qb.pop_front();
                chk("b_crc", b_crc, eb.crc);
                chk("b_src", {31'd0, b_src}, {31'd0, eb.src});
                chk("b_len", {16'd0, b_len}, {16'd0, eb.len});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        int t;
        s = "123456789";
        for (int i = 0; i < 16; i++) begin
            s123[i]  = (i < 9) ? s[i] : 8'h00;
            one_b[i] = (i == 0) ? 8'h01 : 8'h00;
            two_b[i] = (i == 0) ? 8'h02 : 8'h00;
        end
        {a_d0, a_v0, a_l0, a_d1, a_v1, a_l1} = '0;
        {b_d0, b_v0, b_l0, b_d1, b_v1, b_l1} = '0;
        a_cr = 1'b1;
        b_cr = 1'b1;

        do_reset("reset_outputs");

        // CRC-8 check string on req0
        qa.push_back('{32'hF4, 1'b0, 16'd9});
        send(0, 0, s123, 9, 1'b1, -1, 0);
        @(negedge clk);
        chk("valid_drop_after_handshake", {31'd0, a_cv}, 32'd0);

        // Round-robin from reset: req0, req1, then req0 again
        do_reset("reset_before_rr");
        qa.push_back('{32'h07, 1'b0, 16'd1});
        qa.push_back('{32'h07, 1'b1, 16'd1});
        fork
            send(0, 0, one_b, 1, 1'b1, -1, 0);
            send(0, 1, one_b, 1, 1'b1, -1, 0);
        join
        qa.push_back('{32'h07, 1'b0, 16'd1});
        qa.push_back('{32'h07, 1'b1, 16'd1});
        fork
            send(0, 0, one_b, 1, 1'b1, -1, 0);
            send(0, 1, one_b, 1, 1'b1, -1, 0);
        join

        // req1 owns a gapped frame while req0 waits
        idle(3);
        qa.push_back('{32'hF4, 1'b1, 16'd9});
        qa.push_back('{32'h07, 1'b0, 16'd1});
        fork
            send(0, 1, s123, 9, 1'b1, 4, 5);
            begin
                idle(3);
                send(0, 0, one_b, 1, 1'b1, -1, 0);
            end
        join

        // Result back-pressure with both requesters pending
        idle(3);
        a_cr = 1'b0;
        qa.push_back('{32'h07, 1'b0, 16'd1});
        qa.push_back('{32'h07, 1'b1, 16'd1});
        qa.push_back('{32'h0E, 1'b0, 16'd1});
        fork
            begin
                send(0, 0, one_b, 1, 1'b1, -1, 0);
                send(0, 0, two_b, 1, 1'b1, -1, 0);
            end
            begin
                idle(2);
                send(0, 1, one_b, 1, 1'b1, -1, 0);
            end
            begin
                t = 0;
                @(negedge clk);
                while (!a_cv && t < 200) begin
                    t++;
                    @(negedge clk);
                end
                if (t >= 200) begin
                    n_chk++;
                    $display("FAIL hold_timeout: crc_valid never rose");
                end
                repeat (10) begin
                    chk("hold_crc", {24'd0, a_crc}, 32'h07);
                    chk("hold_len_src", {15'd0, a_len, a_src}, 32'd2);
                    chk("hold_no_ready", {30'd0, a_r0, a_r1}, 32'd0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 a_cr = 1'b1;
            end
        join

        // Abort a frame with reset, then resend it cleanly
        idle(3);
        send(0, 0, s123, 4, 1'b0, -1, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_reset_outputs", {a_crc, a_src, a_len, a_cv, a_r0, a_r1}, 32'd0);
        qa.push_back('{32'hF4, 1'b0, 16'd9});
        send(0, 0, s123, 9, 1'b1, -1, 0);

        // Reflected CRC-32 check value
        idle(2);
        qb.push_back('{32'hCBF43926, 1'b0, 16'd9});
        send(1, 0, s123, 9, 1'b1, -1, 0);

        idle(5);
        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
